// File: rtl/four_func_engine.sv
// Horner-method evaluator for four table-driven polynomials sharing one 8-bit adder and one 8x8 multiplier; busy lasts 2*NTERMS cycles.
// Optional macro FOURFUNC_SAT_EN: accumulator saturates to 8'hFF on adder carry (default build wraps).
module four_func_engine #(
  parameter int NTERMS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        NbarT,
  input  logic        start,
  input  logic [1:0]  func,
  input  logic [7:0]  x,
  input  logic [7:0]  tableData,
  output logic [4:0]  addr,
  output logic        busy,
  output logic [3:0]  resultIPart,
  output logic [3:0]  resultFPart,
  input  logic [7:0]  adderinput1,
  input  logic [7:0]  adderinput2,
  input  logic [7:0]  mulinput1,
  input  logic [7:0]  mulinput2,
  output logic [8:0]  adderout,
  output logic [15:0] mulout
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_ADD, S_DONE} state_t;

  localparam logic [2:0] K_INIT = 3'(NTERMS - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_acc;
  logic [15:0] r_prod;
  logic [2:0]  r_k;
  logic [1:0]  r_func;
  logic [7:0]  r_x;
  logic        r_busy;
  logic [3:0]  r_res_i;
  logic [3:0]  r_res_f;

  logic [7:0]  w_a;
  logic [7:0]  w_b;
  logic [7:0]  w_m1;
  logic [7:0]  w_m2;
  logic [7:0]  w_sum_f;
  logic [4:0]  w_addr;
  logic        w_unused;

  // Test mode hands the arithmetic units straight to the pins.
  assign w_a  = NbarT ? adderinput1 : r_prod[15:8];
  assign w_b  = NbarT ? adderinput2 : tableData;
  assign w_m1 = NbarT ? mulinput1   : r_acc;
  assign w_m2 = NbarT ? mulinput2   : r_x;

  assign adderout = {1'b0, w_a} + {1'b0, w_b};
  assign mulout   = {8'h00, w_m1} * {8'h00, w_m2};

`ifdef FOURFUNC_SAT_EN
  assign w_sum_f = adderout[8] ? 8'hFF : adderout[7:0];
`else
  assign w_sum_f = adderout[7:0];
`endif

  // Low product bits are below the Q4.4 accumulator resolution.
  assign w_unused = ^r_prod[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (!NbarT) begin
      case (r_state)
        S_IDLE:  w_next = start ? S_LOAD : S_IDLE;
        S_LOAD:  w_next = S_MUL;
        S_MUL:   w_next = S_ADD;
        S_ADD:   w_next = (r_k == 3'd0) ? S_DONE : S_MUL;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_addr = 5'd0;
    case (r_state)
      S_LOAD, S_ADD: w_addr = {r_func, r_k};
      default:       w_addr = 5'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= 8'd0;
      r_prod  <= 16'd0;
      r_k     <= 3'd0;
      r_func  <= 2'd0;
      r_x     <= 8'd0;
      r_busy  <= 1'b0;
      r_res_i <= 4'd0;
      r_res_f <= 4'd0;
    end else if (!NbarT) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_func <= func;
            r_x    <= x;
            r_k    <= K_INIT;
            r_busy <= 1'b1;
          end
        end
        S_LOAD: begin
          r_acc <= tableData;
          r_k   <= r_k - 3'd1;
        end
        S_MUL: begin
          r_prod <= mulout;
        end
        S_ADD: begin
          r_acc <= w_sum_f;
          if (r_k != 3'd0) begin
            r_k <= r_k - 3'd1;
          end
        end
        S_DONE: begin
          r_res_i <= r_acc[7:4];
          r_res_f <= r_acc[3:0];
          r_busy  <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign addr        = w_addr;
  assign busy        = r_busy;
  assign resultIPart = r_res_i;
  assign resultFPart = r_res_f;

endmodule

// File: tb/tb_four_func_engine.sv
// Directed bench for four_func_engine: test-mode arithmetic, Horner evaluation, start-while-busy, reset abort and test-mode freeze.
module tb_four_func_engine;

  logic        clk;
  logic        rst;
  logic        NbarT;
  logic        start;
  logic [1:0]  func;
  logic [7:0]  x;
  logic [7:0]  tableData;
  logic [4:0]  addr;
  logic        busy;
  logic [3:0]  resultIPart;
  logic [3:0]  resultFPart;
  logic [7:0]  adderinput1;
  logic [7:0]  adderinput2;
  logic [7:0]  mulinput1;
  logic [7:0]  mulinput2;
  logic [8:0]  adderout;
  logic [15:0] mulout;

  logic [7:0]  tbl [0:31];
  int          n_cmp;
  int          n_err;

  four_func_engine #(.NTERMS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .NbarT       (NbarT),
    .start       (start),
    .func        (func),
    .x           (x),
    .tableData   (tableData),
    .addr        (addr),
    .busy        (busy),
    .resultIPart (resultIPart),
    .resultFPart (resultFPart),
    .adderinput1 (adderinput1),
    .adderinput2 (adderinput2),
    .mulinput1   (mulinput1),
    .mulinput2   (mulinput2),
    .adderout    (adderout),
    .mulout      (mulout)
  );

  assign tableData = tbl[addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts an evaluation and follows it until busy drops, counting busy cycles.
  task automatic run_eval(input logic [1:0] f, input logic [7:0] xv, input logic [7:0] exp_acc,
                          input int exp_lat, input bit chk_addr, input int inj_start_at,
                          input int freeze_at);
    int         cyc;
    logic [4:0] snap_addr;
    snap_addr = 5'd0;
    start = 1'b1;
    func  = f;
    x     = xv;
    step();
    func  = ~f;
    x     = ~xv;
    cyc   = 0;
    while (busy && cyc < 40) begin
      start = (cyc == inj_start_at);
      if (chk_addr && (cyc % 2 == 0) && cyc < 8)
        check_eq("addr_seq", addr, {f, 3'(3 - cyc / 2)});
      if (cyc == freeze_at) begin
        NbarT       = 1'b1;
        adderinput1 = 8'hC3;
        mulinput1   = 8'h3C;
        snap_addr   = addr;
      end
      if (freeze_at >= 0 && cyc > freeze_at && cyc <= freeze_at + 3) begin
        check_eq("frz_addr", addr, snap_addr);
        check_eq("frz_busy", busy, 1'b1);
      end
      if (freeze_at >= 0 && cyc == freeze_at + 3)
        NbarT = 1'b0;
      cyc++;
      step();
    end
    start = 1'b0;
    check_eq("latency", cyc, exp_lat);
    check_eq("res_ipart", resultIPart, exp_acc[7:4]);
    check_eq("res_fpart", resultFPart, exp_acc[3:0]);
  endtask

  typedef struct {
    logic [7:0]  a1, a2, m1, m2;
    logic [8:0]  sum;
    logic [15:0] prod;
  } vec_t;

  vec_t vecs [10];
  logic [7:0] exp_f2;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; NbarT = 1'b0; start = 1'b0; func = 2'd0; x = 8'd0;
    adderinput1 = 8'd0; adderinput2 = 8'd0; mulinput1 = 8'd0; mulinput2 = 8'd0;
    for (int i = 0; i < 32; i++) tbl[i] = 8'h55;
    tbl[0] = 8'h10; tbl[1] = 8'h10; tbl[2] = 8'h08; tbl[3] = 8'h03;
    for (int i = 16; i < 20; i++) tbl[i] = 8'hF0;
`ifdef FOURFUNC_SAT_EN
    exp_f2 = 8'hFF;
`else
    exp_f2 = 8'hBD;
`endif

    vecs[0] = '{8'hFF, 8'h01, 8'hFF, 8'hFF, 9'h100, 16'hFE01};
    vecs[1] = '{8'h00, 8'h00, 8'h00, 8'hFF, 9'h000, 16'h0000};
    vecs[2] = '{8'h80, 8'h80, 8'h80, 8'h80, 9'h100, 16'h4000};
    vecs[3] = '{8'h0F, 8'hF0, 8'h10, 8'h10, 9'h0FF, 16'h0100};
    vecs[4] = '{8'hAA, 8'h55, 8'h02, 8'hAA, 9'h0FF, 16'h0154};
    vecs[5] = '{8'hAB, 8'h55, 8'h0F, 8'h0F, 9'h100, 16'h00E1};
    vecs[6] = '{8'h7F, 8'h7F, 8'h7F, 8'h02, 9'h0FE, 16'h00FE};
    vecs[7] = '{8'h12, 8'h34, 8'h12, 8'h34, 9'h046, 16'h03A8};
    vecs[8] = '{8'hC8, 8'h64, 8'hC8, 8'h64, 9'h12C, 16'h4E20};
    vecs[9] = '{8'hFE, 8'hFE, 8'hFE, 8'hFE, 9'h1FC, 16'hFC04};

    step(); step(); step();
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_ipart", resultIPart, 4'd0);
    check_eq("rst_fpart", resultFPart, 4'd0);
    check_eq("rst_addr", addr, 5'd0);
    rst = 1'b0;
    step();

    NbarT = 1'b1;
    for (int i = 0; i < 10; i++) begin
      adderinput1 = vecs[i].a1; adderinput2 = vecs[i].a2;
      mulinput1   = vecs[i].m1; mulinput2   = vecs[i].m2;
      #1;
      check_eq($sformatf("tm_add%0d", i), adderout, vecs[i].sum);
      check_eq($sformatf("tm_mul%0d", i), mulout, vecs[i].prod);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_eq("tm_start_ignored", busy, 1'b0);
    NbarT = 1'b0;
    step();

    run_eval(2'd0, 8'h80, 8'h1A, 8, 1'b1, -1, -1);
    run_eval(2'd2, 8'hFF, exp_f2, 8, 1'b1, -1, -1);
    run_eval(2'd0, 8'h80, 8'h1A, 8, 1'b1, 2, -1);
    step(); step(); step();
    check_eq("no_second_run", busy, 1'b0);

    start = 1'b1; func = 2'd2; x = 8'hFF;
    step();
    start = 1'b0;
    step(); step(); step();
    check_eq("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_ipart", resultIPart, 4'd0);
    check_eq("abort_fpart", resultFPart, 4'd0);
    step();
    rst = 1'b0;
    step();
    run_eval(2'd0, 8'h80, 8'h1A, 8, 1'b1, -1, -1);

    run_eval(2'd2, 8'hFF, exp_f2, 11, 1'b0, -1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/four_func_engine.md
Name: four_func_engine

Overview:
- Fixed-point evaluator for four polynomial-approximated functions (e.g. exp, sin, cos, ln), selected by func.
- Evaluates by Horner's method using one shared 8-bit adder and one shared 8x8 multiplier, with coefficients read from an external combinational coefficient table.
- Test mode (NbarT=1) exposes the adder and multiplier directly at the pins for partial-scan style testing of the arithmetic units.

Parameters:
- NTERMS, 4, number of polynomial coefficients per function (2..8); degree = NTERMS-1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- NbarT  in  1  0 = normal mode, 1 = test mode
- start  in  1  single-cycle start request
- func  in  2  function select
- x  in  8  argument, unsigned Q0.8
- tableData  in  8  coefficient read from table, unsigned Q4.4, combinational w.r.t. addr
- addr  out  5  table address {func, k[2:0]}
- busy  out  1  high while evaluating
- resultIPart  out  4  result integer part
- resultFPart  out  4  result fraction part
- adderinput1, adderinput2  in  8  adder operands in test mode
- mulinput1, mulinput2  in  8  multiplier operands in test mode
- adderout  out  9  shared adder sum, combinational, full carry
- mulout  out  16  shared multiplier product, combinational, unsigned

Behaviour:
- Shared units: adderout = A + B (9 bits); mulout = M1 * M2 (16 bits).
  - Operand mux: NbarT=1 selects the adderinput*/mulinput* pins; NbarT=0 selects internal FSM operands.
  - adderout and mulout are always driven in both modes.
- Registers: acc[7:0] (Q4.4), prod[15:0], k[2:0], state, busy, results.
- Reset (rst=1, asynchronous): state=IDLE, busy=0, acc=0, prod=0, k=0, addr=0, resultIPart=0, resultFPart=0.
- FSM, normal mode (NbarT=0):
  - IDLE: addr=0. On start=1, latch func and x, set k=NTERMS-1, go to LOAD. busy=1 from the next cycle.
  - LOAD: addr={func,k}; acc<=tableData; k<=k-1; go to MUL.
  - MUL: prod<=mulout(acc, x) (Q4.12); go to ADD.
  - ADD: addr={func,k}; acc<=f(prod[15:8] + tableData).
    - If k==0, go to DONE; else k<=k-1 and go to MUL.
  - DONE: resultIPart<=acc[7:4]; resultFPart<=acc[3:0]; busy<=0; go to IDLE.
- Latency: busy high for 2*NTERMS cycles (8 for NTERMS=4). Results are valid in the cycle busy falls and are held until the next completion or reset.
- start while busy is ignored. func and x changes after the start cycle have no effect.
- Test mode (NbarT=1): FSM state and all registers hold their values, start is ignored, busy and result outputs hold. Deasserting NbarT resumes the FSM from the held state.
- Reset mid-operation aborts evaluation immediately; results return to 0.

Optional Feature:
- Macro FOURFUNC_SAT_EN.
  - Defined: f() saturates, so acc=8'hFF when the adder carry (adderout[8]) is set.
  - Undefined: f() wraps, so acc=adderout[7:0].
- The test-mode adderout is the full 9-bit sum in both cases.

Test Plan:
- NbarT=1, adderinput1=8'hFF, adderinput2=8'h01, mulinput1=8'hFF, mulinput2=8'hFF -> adderout=9'h100, mulout=16'hFE01. Also check 8 random operand vectors: adderout = sum, mulout = product.
- NbarT=0, func=0, table {c0..c3}={10,10,08,03}, x=8'h80, start pulse -> busy high 8 cycles; addr sequence 3,2,1,0; then resultIPart=1, resultFPart=4'hA (acc=8'h1A).
- func=2, all coefficients 8'hF0, x=8'hFF.
  - With FOURFUNC_SAT_EN -> resultIPart=4'hF, resultFPart=4'hF.
  - Without -> acc=8'hBD, so resultIPart=4'hB, resultFPart=4'hD.
- Start pulse again while busy -> ignored; single completion with unchanged results timing.
- Assert rst in the 4th busy cycle -> busy=0, results=0 immediately; a new start afterwards completes normally.
- Raise NbarT for 3 cycles mid-evaluation -> busy and state frozen; after release, completes with the same result, latency extended by 3 cycles.
